// File: rtl/rv32_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv32_mem_pkg
//  Description : funct3 encodings, MEM-stage FSM state encoding and small
//                decode helpers shared by the load/store engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

  // funct3 encodings shared by loads and stores (BU/HU are load-only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // True when funct3 names a real load (is_load=1) or store (is_load=0)
  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_load);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural-alignment check on the byte offset for the access size
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mem_access_unit_if
//  Description : Pipeline-side and data-memory-side signals of the MEM-stage
//                load/store engine. slave = the engine, master = its
//                environment (pipeline + data memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busywait;
  logic [31:0] rdata_out;
  logic        misaligned;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata, mem_rdata, mem_ack,
    output busywait, rdata_out, misaligned, bus_error,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output mem_read, mem_write, funct3, addr, wdata, mem_rdata, mem_ack,
    input  busywait, rdata_out, misaligned, bus_error,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Selects the addressed byte/half lane of a raw read word and
//                sign- or zero-extends it to 32 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import rv32_mem_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;

  assign w_byte_sh = raw_i >> {off_i, 3'b000};
  assign w_half_sh = raw_i >> {off_i[1], 4'b0000};

  // Lane select and extension; funct3[2] marks the unsigned variants
  always_comb begin
    data_o = raw_i;
    case (funct3_i)
      F3_B:    data_o = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      F3_BU:   data_o = {24'h0, w_byte_sh[7:0]};
      F3_H:    data_o = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      F3_HU:   data_o = {16'h0, w_half_sh[15:0]};
      default: data_o = raw_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : RV32IM MEM-stage load/store engine. Formats stores, runs a
//                req/ack handshake to data memory, formats loads and stalls
//                the whole pipeline (busywait) until the access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  localparam int unsigned      CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       f3_q, f3_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             berr_q, berr_d;

  logic             w_active, w_fault, w_fault_now, w_start, w_timeout;
  logic [3:0]       w_st_be;
  logic [31:0]      w_st_wdata, w_ld_data;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_active  = bus.mem_read | bus.mem_write;
  assign w_fault   = w_active &&
                     ((bus.mem_read && bus.mem_write) ||
                      !funct3_legal(bus.funct3, bus.mem_read) ||
                      addr_misaligned(bus.funct3, bus.addr[1:0]));
  // Faults and new accesses are only recognised in IDLE; in DONE the inputs
  // still show the instruction that just completed.
  assign w_fault_now = (state_q == ST_IDLE) && w_fault;
  assign w_start     = (state_q == ST_IDLE) && w_active && !w_fault;
  assign w_cnt_inc   = cnt_q + CNT_W'(1);
  // A same-cycle ack wins over the timeout
  assign w_timeout   = TIMEOUT_EN && (state_q == ST_ACCESS) && !bus.mem_ack &&
                       (w_cnt_inc == CNT_LIMIT);

  load_align u_load_align (
    .raw_i    (bus.mem_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (w_ld_data)
  );

  // Store lane enables and lane-replicated write data; reads use all lanes
  always_comb begin
    w_st_be    = 4'hF;
    w_st_wdata = bus.wdata;
    if (bus.mem_write) begin
      case (bus.funct3[1:0])
        2'b00: begin
          w_st_be    = 4'b0001 << bus.addr[1:0];
          w_st_wdata = {4{bus.wdata[7:0]}};
        end
        2'b01: begin
          w_st_be    = 4'b0011 << {bus.addr[1], 1'b0};
          w_st_wdata = {2{bus.wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // State register; async reset drops mem_req immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_start) state_d = ST_ACCESS;
      ST_ACCESS: if (bus.mem_ack || w_timeout) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: latch bus request, capture load result or timeout
  always_comb begin
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    berr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_start) begin
          addr_d  = bus.addr;
          f3_d    = bus.funct3;
          we_d    = bus.mem_write;
          be_d    = w_st_be;
          wdata_d = w_st_wdata;
          cnt_d   = '0;
        end else if (w_fault) begin
          rdata_d = '0;
        end
      end
      ST_ACCESS: begin
        if (bus.mem_ack) begin
          cnt_d = '0;
          if (!we_q) rdata_d = w_ld_data;
        end else if (w_timeout) begin
          cnt_d   = '0;
          berr_d  = 1'b1;
          rdata_d = '0;
        end else if (TIMEOUT_EN) begin
          cnt_d = w_cnt_inc;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
    end
  end

  // Outputs; the combinational stall/fault terms are masked while in reset
  always_comb begin
    bus.busywait   = !rst && (w_start || (state_q == ST_ACCESS));
    bus.mem_req    = (state_q == ST_ACCESS);
    bus.misaligned = !rst && w_fault_now;
    bus.rdata_out  = w_fault_now ? 32'h0 : rdata_q;
    bus.bus_error  = berr_q;
    bus.mem_we     = we_q;
    bus.mem_addr   = {addr_q[31:2], 2'b00};
    bus.mem_be     = be_q;
    bus.mem_wdata  = wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Scoreboard bench for mem_access_unit: driver issues
//                instructions and pushes expected responses, a memory model
//                answers requests, a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 4;

  typedef struct {
    bit          fault;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] rdata;
    bit          berr;
    int          stalls;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] word;
  } mem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  mem_t mem_q[$];
  bit   mon_en   = 1'b1;
  int   late_req = 0;
  int   late_done = 0;

  logic [2:0] LD_F3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] ST_F3 [3] = '{3'd0, 3'd1, 3'd2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model from the architectural rules
  function automatic exp_t model(bit rd, bit wr, logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] wd, logic [31:0] word, int lat);
    exp_t e;
    int size, off;
    bit legal;
    logic [31:0] v, mask;
    e = '{default: '0};
    off  = int'(a % 4);
    size = 1 << f3[1:0];
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    e.fault = (rd && wr) || !legal || ((off % size) != 0);
    if (e.fault) return e;
    e.we   = wr;
    e.addr = a - 32'(off);
    if (wr) begin
      e.be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
    end else begin
      e.be = 4'hF;
    end
    if (lat < 0) begin
      e.berr = 1; e.chk_rd = 1; e.rdata = 32'h0; e.stalls = 1 + TO;
    end else begin
      e.stalls = 2 + lat;
      if (rd) begin
        v = word >> (8 * off);
        if (size < 4) begin
          mask = (32'h1 << (8 * size)) - 32'h1;
          v = v & mask;
          if (!f3[2] && v[8*size-1]) v = v | ~mask;
        end
        e.chk_rd = 1; e.rdata = v;
      end
    end
    return e;
  endfunction

  // Driver: present one instruction, hold it until the stall releases
  task automatic issue(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int lat);
    exp_t e;
    mem_t m;
    int n;
    if (rd || wr) begin
      e = model(rd, wr, f3, a, wd, word, lat);
      exp_q.push_back(e);
      if (!e.fault) begin
        m.lat = lat; m.word = word;
        mem_q.push_back(m);
      end
    end
    bus.mem_read = rd; bus.mem_write = wr; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busywait && n < 30);
    if (n >= 30) chk("stall_release_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Data memory model: acks after the requested number of ACCESS cycles
  initial begin : p_mem
    mem_t mc;
    bit   m_act;
    int   m_cnt;
    m_act = 0; m_cnt = 0; mc.lat = -1; mc.word = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (late_req > late_done) begin
        late_done++;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
      end else if (!bus.mem_req) begin
        m_act = 0;
      end else begin
        if (!m_act) begin
          if (mem_q.size() == 0) begin
            chk("unexpected_mem_req", 32'd1, 32'd0);
            mc.lat = -1;
          end else begin
            mc = mem_q.pop_front();
          end
          m_act = 1; m_cnt = 0;
        end
        if (mc.lat >= 0 && m_cnt == mc.lat) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mc.word;
        end else begin
          bus.mem_rdata = $urandom;
        end
        m_cnt++;
      end
    end
  end

  // Monitor: pops expected records on fault, request start and completion
  bit          have_cur = 0;
  exp_t        cur;
  int          bw_cnt = 0;
  bit          last_valid = 0;
  logic [31:0] last_rd = '0;

  initial begin : p_mon
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (bus.busywait) bw_cnt++;
        if (bus.misaligned) begin
          if (exp_q.size() == 0) chk("unexpected_fault", 32'd1, 32'd0);
          else begin
            cur = exp_q.pop_front();
            chk("fault_expected", 32'(cur.fault), 32'd1);
            chk("fault_busywait", 32'(bus.busywait), 32'd0);
            chk("fault_rdata_out", bus.rdata_out, 32'h0);
            chk("fault_mem_req", 32'(bus.mem_req), 32'd0);
            last_valid = 0;
          end
        end
        if (!have_cur && bus.mem_req) begin
          if (exp_q.size() == 0) chk("unexpected_access", 32'd1, 32'd0);
          else begin
            cur = exp_q.pop_front();
            chk("access_not_fault", 32'(cur.fault), 32'd0);
            chk("mem_addr", bus.mem_addr, cur.addr);
            chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
            chk("mem_be", 32'(bus.mem_be), 32'(cur.be));
            if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
            have_cur = 1;
          end
        end else if (have_cur && !bus.busywait) begin
          chk("stall_cycles", 32'(bw_cnt), 32'(cur.stalls));
          chk("bus_error", 32'(bus.bus_error), 32'(cur.berr));
          if (cur.chk_rd) begin
            chk("rdata_out", bus.rdata_out, cur.rdata);
            last_rd = cur.rdata; last_valid = 1;
          end
          have_cur = 0;
        end else if (bus.bus_error) begin
          chk("stray_bus_error", 32'd1, 32'd0);
        end else if (!have_cur && !bus.busywait && !bus.mem_read && !bus.mem_write && last_valid) begin
          chk("noop_rdata_hold", bus.rdata_out, last_rd);
        end
        if (!bus.busywait) bw_cnt = 0;
      end
    end
  end

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    bus.mem_read = 0; bus.mem_write = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busywait", 32'(bus.busywait), 32'd0);
    chk("reset_mem_req", 32'(bus.mem_req), 32'd0);
    chk("reset_rdata_out", bus.rdata_out, 32'h0);
    chk("reset_mem_be", 32'(bus.mem_be), 32'd0);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    issue(1, 0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 0, 3'b000, 32'h0,   32'h0, 32'h0, 0);
    issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1);
    issue(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0);
    issue(1, 0, 3'b101, 32'h102, 32'h0, 32'h80112233, 2);
    issue(0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0);
    issue(0, 1, 3'b001, 32'h202, 32'h0000CDEF, 32'h0, 3);
    issue(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    issue(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, -1);
    issue(0, 0, 3'b000, 32'h0,   32'h0, 32'h0, 0);

    // Randomized instruction stream
    for (int k = 0; k < 80; k++) begin
      int r, size, lat;
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      rd = (r < 45) || (r >= 85 && r < 90);
      wr = (r >= 45 && r < 90);
      if ($urandom_range(0, 9) < 8) f3 = wr && !rd ? ST_F3[$urandom_range(0, 2)] : LD_F3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      size = 1 << f3[1:0];
      if ($urandom_range(0, 9) < 7) a = a & ~(32'(size) - 32'd1);
      lat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
      issue(rd, wr, f3, a, $urandom, $urandom, lat);
    end

    issue(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    chk("monitor_idle", 32'(have_cur), 32'd0);

    // Asynchronous reset in the middle of an access; the late ack is ignored
    mon_en = 0;
    bus.mem_read = 1; bus.mem_write = 0; bus.funct3 = 3'b010; bus.addr = 32'h104;
    @(posedge clk);
    #2;
    chk("pre_rst_mem_req", 32'(bus.mem_req), 32'd1);
    chk("pre_rst_busywait", 32'(bus.busywait), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("async_rst_busywait", 32'(bus.busywait), 32'd0);
    #1;
    rst = 1'b0;
    bus.mem_read = 0;
    late_req++;
    @(posedge clk); #1;
    chk("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
    chk("late_ack_busywait", 32'(bus.busywait), 32'd0);
    chk("late_ack_rdata_out", bus.rdata_out, 32'h0);
    chk("late_ack_bus_error", 32'(bus.bus_error), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_idle_mem_req", 32'(bus.mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
